// File: rtl/rggen_rtl_pkg.sv
// Shared rggen types: bus status encoding and the AXI4-Lite bridge FSM states.
package rggen_rtl_pkg;
  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    RGGEN_AXI4LITE_IDLE     = 2'd0,
    RGGEN_AXI4LITE_ACCESS   = 2'd1,
    RGGEN_AXI4LITE_RESPONSE = 2'd2
  } rggen_axi4lite_bridge_state;
endpackage

// File: rtl/rggen_bus_if.sv
// Single-request register bus between a protocol bridge and the register adapter.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                       valid;
  logic [ADDRESS_WIDTH-1:0]   address;
  logic                       write;
  logic [BUS_WIDTH-1:0]       write_data;
  logic [BUS_WIDTH/8-1:0]     strobe;
  logic                       ready;
  rggen_rtl_pkg::rggen_status status;
  logic [BUS_WIDTH-1:0]       read_data;

  modport master (
    output valid, address, write, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, address, write, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_request_holder.sv
// One-deep valid/ready capture register; holds a request until the consumer clears it.
module rggen_request_holder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);
  logic             full;
  logic [WIDTH-1:0] data;

  // clear only arrives while full, when ready is already low, so it never races a capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (i_clear) begin
      full <= 1'b0;
    end else if (i_valid && !full) begin
      full <= 1'b1;
      data <= i_data;
    end
  end

  assign o_ready = !full;
  assign o_full  = full;
  assign o_data  = data;
endmodule

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave to rggen_bus_if master; one transaction in flight, round-robin read/write.
module rggen_axi4lite_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [BUS_WIDTH-1:0]     i_wdata,
  input  logic [BUS_WIDTH/8-1:0]   i_wstrb,
  output logic                     o_bvalid,
  input  logic                     i_bready,
  output logic [1:0]               o_bresp,
  input  logic                     i_arvalid,
  output logic                     o_arready,
  input  logic [ADDRESS_WIDTH-1:0] i_araddr,
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [BUS_WIDTH-1:0]     o_rdata,
  output logic [1:0]               o_rresp,
  rggen_bus_if.master              bus_if
);
  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'((1 << LSB) - 1);

  rggen_axi4lite_bridge_state state;

  logic                      aw_full, w_full, ar_full;
  logic [ADDRESS_WIDTH-1:0]  aw_addr, ar_addr;
  logic [STRB_W+BUS_WIDTH-1:0] w_bundle;
  logic [BUS_WIDTH-1:0]      w_data;
  logic [STRB_W-1:0]         w_strb;
  logic                      wr_pend, rd_pend, grant_write, access_done;
  logic                      write_first;
  logic                      bus_valid, bus_write;
  logic [ADDRESS_WIDTH-1:0]  bus_address;
  logic [BUS_WIDTH-1:0]      bus_wdata;
  logic [STRB_W-1:0]         bus_strobe;
  logic                      bvalid, rvalid;
  rggen_status               resp;
  logic [BUS_WIDTH-1:0]      rdata;

  assign access_done = (state == RGGEN_AXI4LITE_ACCESS) && bus_if.ready;

  rggen_request_holder #(.WIDTH(ADDRESS_WIDTH)) u_aw (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_awvalid),
    .o_ready (o_awready),
    .i_data  (i_awaddr),
    .i_clear (access_done && bus_write),
    .o_full  (aw_full),
    .o_data  (aw_addr)
  );

  rggen_request_holder #(.WIDTH(STRB_W + BUS_WIDTH)) u_w (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_wvalid),
    .o_ready (o_wready),
    .i_data  ({i_wstrb, i_wdata}),
    .i_clear (access_done && bus_write),
    .o_full  (w_full),
    .o_data  (w_bundle)
  );

  rggen_request_holder #(.WIDTH(ADDRESS_WIDTH)) u_ar (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_arvalid),
    .o_ready (o_arready),
    .i_data  (i_araddr),
    .i_clear (access_done && !bus_write),
    .o_full  (ar_full),
    .o_data  (ar_addr)
  );

  assign w_data      = w_bundle[BUS_WIDTH-1:0];
  assign w_strb      = w_bundle[STRB_W+BUS_WIDTH-1:BUS_WIDTH];
  assign wr_pend     = aw_full && w_full;
  assign rd_pend     = ar_full;
  assign grant_write = wr_pend && (!rd_pend || write_first);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= RGGEN_AXI4LITE_IDLE;
      write_first <= 1'b1;
      bus_valid   <= 1'b0;
      bus_write   <= 1'b0;
      bus_address <= '0;
      bus_wdata   <= '0;
      bus_strobe  <= '0;
      bvalid      <= 1'b0;
      rvalid      <= 1'b0;
      resp        <= RGGEN_OKAY;
      rdata       <= '0;
    end else begin
      case (state)
        RGGEN_AXI4LITE_IDLE: begin
          if (wr_pend || rd_pend) begin
            state     <= RGGEN_AXI4LITE_ACCESS;
            bus_valid <= 1'b1;
            if (grant_write) begin
              bus_write   <= 1'b1;
              bus_address <= aw_addr & ADDR_MASK;
              bus_wdata   <= w_data;
              bus_strobe  <= w_strb;
            end else begin
              bus_write   <= 1'b0;
              bus_address <= ar_addr & ADDR_MASK;
              bus_wdata   <= '0;
              bus_strobe  <= '1;
            end
            // priority only rotates when the two sides actually contend
            if (wr_pend && rd_pend) write_first <= !write_first;
          end
        end
        RGGEN_AXI4LITE_ACCESS: begin
          if (bus_if.ready) begin
            state     <= RGGEN_AXI4LITE_RESPONSE;
            bus_valid <= 1'b0;
            resp      <= bus_if.status;
            rdata     <= bus_write ? '0 : bus_if.read_data;
            bvalid    <= bus_write;
            rvalid    <= !bus_write;
          end
        end
        RGGEN_AXI4LITE_RESPONSE: begin
          if ((bvalid && i_bready) || (rvalid && i_rready)) begin
            state  <= RGGEN_AXI4LITE_IDLE;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
          end
        end
        default: state <= RGGEN_AXI4LITE_IDLE;
      endcase
    end
  end

  assign bus_if.valid      = bus_valid;
  assign bus_if.address    = bus_address;
  assign bus_if.write      = bus_write;
  assign bus_if.write_data = bus_wdata;
  assign bus_if.strobe     = bus_strobe;
  assign o_bvalid          = bvalid;
  assign o_rvalid          = rvalid;
  assign o_bresp           = resp;
  assign o_rresp           = resp;
  assign o_rdata           = rdata;
endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Bench for rggen_axi4lite_bridge: directed scenarios plus random traffic against a queue-based model.
module tb_rggen_axi4lite_bridge;
  import rggen_rtl_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_awvalid = 1'b0, i_wvalid = 1'b0, i_arvalid = 1'b0;
  logic        i_bready = 1'b1, i_rready = 1'b1;
  logic [7:0]  i_awaddr = '0, i_araddr = '0;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_wstrb = '0;
  logic        o_awready, o_wready, o_arready, o_bvalid, o_rvalid;
  logic [1:0]  o_bresp, o_rresp;
  logic [31:0] o_rdata;

  always #5 i_clk = ~i_clk;

  rggen_bus_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus_if ();

  rggen_axi4lite_bridge #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .bus_if(bus_if)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // slave side of bus_if
  bit          slave_rand = 1'b0;
  int          dir_dly = 0;
  rggen_status dir_status = RGGEN_OKAY;
  logic [31:0] dir_rdata = '0;
  int          s_cnt = 0, s_dly = 0;
  rggen_status s_st = RGGEN_OKAY;
  logic [31:0] s_rd = '0;

  initial begin
    bus_if.ready = 1'b0;
    bus_if.status = RGGEN_OKAY;
    bus_if.read_data = '0;
    forever begin
      @(posedge i_clk); #2;
      if (bus_if.valid) begin
        if (s_cnt >= s_dly) begin
          bus_if.ready = 1'b1;
          bus_if.status = s_st;
          bus_if.read_data = s_rd;
        end else begin
          bus_if.ready = 1'b0;
          s_cnt++;
          if (slave_rand) begin
            bus_if.status = rggen_status'($urandom_range(0, 3));
            bus_if.read_data = $urandom;
          end
        end
      end else begin
        bus_if.ready = 1'b0;
        s_cnt = 0;
        s_dly = slave_rand ? int'($urandom_range(0, 3)) : dir_dly;
        s_st  = slave_rand ? rggen_status'($urandom_range(0, 3)) : dir_status;
        s_rd  = slave_rand ? $urandom : dir_rdata;
        bus_if.status = s_st;
        bus_if.read_data = s_rd;
      end
    end
  end

  // transaction-level model: one-deep request queues, an in-flight kind, and a response slot
  logic [7:0]  q_aw[$];
  logic [7:0]  q_ar[$];
  logic [31:0] q_wd[$];
  logic [3:0]  q_ws[$];
  int          m_kind = 0;      // 0 none, 1 write, 2 read
  bit          m_acc = 1'b0;    // in-flight request still on the bus
  bit          m_wfirst = 1'b1;
  logic [1:0]  m_resp = '0;
  logic [31:0] m_rdata = '0;
  bit          hs_aw = 1'b0, hs_w = 1'b0, hs_ar = 1'b0;

  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) begin
      chk("rst_awready", o_awready, 1);
      chk("rst_wready", o_wready, 1);
      chk("rst_arready", o_arready, 1);
      chk("rst_bus_valid", bus_if.valid, 0);
      chk("rst_bus_write", bus_if.write, 0);
      chk("rst_bus_addr", bus_if.address, 0);
      chk("rst_bus_wdata", bus_if.write_data, 0);
      chk("rst_bus_strobe", bus_if.strobe, 0);
      chk("rst_bvalid", o_bvalid, 0);
      chk("rst_rvalid", o_rvalid, 0);
      chk("rst_resp", {o_bresp, o_rresp}, 0);
      chk("rst_rdata", o_rdata, 0);
      q_aw.delete(); q_ar.delete(); q_wd.delete(); q_ws.delete();
      m_kind = 0; m_acc = 1'b0; m_wfirst = 1'b1; m_resp = '0; m_rdata = '0;
      hs_aw = 1'b0; hs_w = 1'b0; hs_ar = 1'b0;
    end else begin
      bit cap_aw, cap_w, cap_ar, wp, rp, exp_v;
      chk("awready", o_awready, q_aw.size() == 0);
      chk("wready", o_wready, q_wd.size() == 0);
      chk("arready", o_arready, q_ar.size() == 0);
      exp_v = (m_kind != 0) && m_acc;
      chk("bus_valid", bus_if.valid, exp_v);
      if (exp_v && m_kind == 1) begin
        chk("bus_addr_w", bus_if.address, q_aw[0] & 8'hFC);
        chk("bus_write_w", bus_if.write, 1);
        chk("bus_wdata_w", bus_if.write_data, q_wd[0]);
        chk("bus_strobe_w", bus_if.strobe, q_ws[0]);
      end
      if (exp_v && m_kind == 2) begin
        chk("bus_addr_r", bus_if.address, q_ar[0] & 8'hFC);
        chk("bus_write_r", bus_if.write, 0);
        chk("bus_wdata_r", bus_if.write_data, 0);
        chk("bus_strobe_r", bus_if.strobe, 4'hF);
      end
      chk("bvalid", o_bvalid, m_kind == 1 && !m_acc);
      chk("rvalid", o_rvalid, m_kind == 2 && !m_acc);
      if (m_kind == 1 && !m_acc) chk("bresp", o_bresp, m_resp);
      if (m_kind == 2 && !m_acc) begin
        chk("rresp", o_rresp, m_resp);
        chk("rdata", o_rdata, m_rdata);
      end

      hs_aw = i_awvalid && o_awready;
      hs_w  = i_wvalid && o_wready;
      hs_ar = i_arvalid && o_arready;
      cap_aw = i_awvalid && q_aw.size() == 0;
      cap_w  = i_wvalid && q_wd.size() == 0;
      cap_ar = i_arvalid && q_ar.size() == 0;

      if (m_kind == 0) begin
        wp = q_aw.size() != 0 && q_wd.size() != 0;
        rp = q_ar.size() != 0;
        if (wp || rp) begin
          m_kind = (wp && (!rp || m_wfirst)) ? 1 : 2;
          if (wp && rp) m_wfirst = !m_wfirst;
          m_acc = 1'b1;
        end
      end else if (m_acc) begin
        if (bus_if.ready) begin
          m_resp = bus_if.status;
          m_rdata = (m_kind == 2) ? bus_if.read_data : 32'h0;
          if (m_kind == 1) begin
            void'(q_aw.pop_front()); void'(q_wd.pop_front()); void'(q_ws.pop_front());
          end else begin
            void'(q_ar.pop_front());
          end
          m_acc = 1'b0;
        end
      end else if ((m_kind == 1) ? i_bready : i_rready) begin
        m_kind = 0;
      end

      if (cap_aw) q_aw.push_back(i_awaddr);
      if (cap_w) begin q_wd.push_back(i_wdata); q_ws.push_back(i_wstrb); end
      if (cap_ar) q_ar.push_back(i_araddr);
    end
  end

  // random AXI master; holds each valid until its handshake
  bit drv_on = 1'b0, rand_en = 1'b0;
  initial forever begin
    @(posedge i_clk); #1;
    if (drv_on) begin
      if (!i_awvalid || hs_aw) begin
        i_awvalid = rand_en && ($urandom_range(0, 2) == 0);
        i_awaddr = 8'($urandom);
      end
      if (!i_wvalid || hs_w) begin
        i_wvalid = rand_en && ($urandom_range(0, 2) == 0);
        i_wdata = $urandom;
        i_wstrb = 4'($urandom);
      end
      if (!i_arvalid || hs_ar) begin
        i_arvalid = rand_en && ($urandom_range(0, 2) == 0);
        i_araddr = 8'($urandom);
      end
      i_bready = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      i_rready = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic get_access(input string nm, output logic wr, output logic [7:0] a);
    int n;
    wr = 1'b0; a = '0; n = 0;
    while (n < 40) begin
      @(negedge i_clk);
      if (bus_if.valid) break;
      n++;
    end
    chk({nm, "_start_in_time"}, n < 40, 1);
    if (n >= 40) return;
    wr = bus_if.write;
    a = bus_if.address;
    n = 0;
    while (n < 40) begin
      @(negedge i_clk);
      if (!bus_if.valid) break;
      n++;
    end
    chk({nm, "_end_in_time"}, n < 40, 1);
  endtask

  task automatic send(input bit aw, input bit w, input bit ar, input logic [7:0] wa,
                      input logic [31:0] wd, input logic [3:0] ws, input logic [7:0] ra);
    step();
    i_awvalid = aw; i_awaddr = wa;
    i_wvalid = w; i_wdata = wd; i_wstrb = ws;
    i_arvalid = ar; i_araddr = ra;
    step();
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
  endtask

  logic       wr;
  logic [7:0] a;

  initial begin
    repeat (3) @(negedge i_clk);
    chk("reset_awready", o_awready, 1);
    chk("reset_bus_strobe", bus_if.strobe, 0);
    step();
    i_rst_n = 1'b1;

    // single write, slave waits 2 cycles
    dir_dly = 2; dir_status = RGGEN_OKAY;
    send(1, 1, 0, 8'h10, 32'hDEADBEEF, 4'hF, 8'h00);
    @(negedge i_clk); chk("w1_no_valid_yet", bus_if.valid, 0);
    @(negedge i_clk); chk("w1_valid_c1", bus_if.valid, 1);
    chk("w1_addr", bus_if.address, 8'h10);
    chk("w1_write", bus_if.write, 1);
    chk("w1_wdata", bus_if.write_data, 32'hDEADBEEF);
    @(negedge i_clk); chk("w1_valid_c2", bus_if.valid, 1);
    @(negedge i_clk); chk("w1_valid_c3", bus_if.valid, 1);
    @(negedge i_clk); chk("w1_valid_dropped", bus_if.valid, 0);
    chk("w1_bvalid", o_bvalid, 1);
    chk("w1_bresp", o_bresp, 0);
    chk("w1_awready_back", o_awready, 1);
    @(negedge i_clk); chk("w1_bvalid_done", o_bvalid, 0);

    // W leads AW by 3 cycles
    dir_dly = 0;
    send(0, 1, 0, 8'h00, 32'h0000A5A5, 4'h3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("w2_wready_held", o_wready, 0);
      chk("w2_no_valid", bus_if.valid, 0);
    end
    send(1, 0, 0, 8'h04, 32'h0, 4'h0, 8'h00);
    @(negedge i_clk); chk("w2_no_valid_at_hs", bus_if.valid, 0);
    @(negedge i_clk); chk("w2_valid", bus_if.valid, 1);
    chk("w2_addr", bus_if.address, 8'h04);
    chk("w2_strobe", bus_if.strobe, 4'h3);
    repeat (3) step();

    // read with SLAVE_ERROR
    dir_status = RGGEN_SLAVE_ERROR; dir_rdata = 32'h12345678;
    send(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'h08);
    @(negedge i_clk);
    @(negedge i_clk); chk("r1_valid", bus_if.valid, 1);
    chk("r1_addr", bus_if.address, 8'h08);
    chk("r1_write", bus_if.write, 0);
    chk("r1_strobe", bus_if.strobe, 4'hF);
    @(negedge i_clk); chk("r1_rvalid", o_rvalid, 1);
    chk("r1_rdata", o_rdata, 32'h12345678);
    chk("r1_rresp", o_rresp, 2);
    repeat (3) step();

    // contention twice: write first, then read first
    dir_status = RGGEN_OKAY; dir_rdata = 32'h0;
    send(1, 1, 1, 8'h20, 32'h11111111, 4'hF, 8'h24);
    get_access("arb1a", wr, a); chk("arb1a_write", wr, 1); chk("arb1a_addr", a, 8'h20);
    get_access("arb1b", wr, a); chk("arb1b_write", wr, 0); chk("arb1b_addr", a, 8'h24);
    repeat (3) step();
    send(1, 1, 1, 8'h30, 32'h22222222, 4'hF, 8'h34);
    get_access("arb2a", wr, a); chk("arb2a_write", wr, 0); chk("arb2a_addr", a, 8'h34);
    get_access("arb2b", wr, a); chk("arb2b_write", wr, 1); chk("arb2b_addr", a, 8'h30);
    repeat (3) step();

    // unaligned read with R backpressure; a write waits behind it
    i_rready = 1'b0; dir_dly = 1; dir_rdata = 32'hCAFEF00D;
    send(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'h13);
    get_access("ua", wr, a); chk("ua_addr", a, 8'h10);
    chk("ua_rvalid", o_rvalid, 1);
    chk("ua_rdata", o_rdata, 32'hCAFEF00D);
    send(1, 1, 0, 8'h3C, 32'h77, 4'hF, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("ua_hold_rvalid", o_rvalid, 1);
      chk("ua_hold_rdata", o_rdata, 32'hCAFEF00D);
      chk("ua_hold_no_valid", bus_if.valid, 0);
    end
    step(); i_rready = 1'b1;
    get_access("ua_next", wr, a); chk("ua_next_write", wr, 1); chk("ua_next_addr", a, 8'h3C);
    repeat (3) step();

    // reset during ACCESS, with a lone AW parked
    send(1, 0, 0, 8'h08, 32'h0, 4'h0, 8'h00);
    dir_dly = 6;
    send(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'h2C);
    begin
      int n = 0;
      while (n < 20 && !bus_if.valid) begin @(negedge i_clk); n++; end
      chk("rst_mid_reached_access", bus_if.valid, 1);
    end
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus_if.valid, 0);
    chk("rst_mid_addr", bus_if.address, 0);
    chk("rst_mid_strobe", bus_if.strobe, 0);
    chk("rst_mid_awready", o_awready, 1);
    chk("rst_mid_arready", o_arready, 1);
    chk("rst_mid_rvalid", o_rvalid, 0);
    step(); step();
    i_rst_n = 1'b1;
    dir_dly = 1; dir_status = RGGEN_OKAY; dir_rdata = 32'h0BADF00D;
    send(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'h18);
    get_access("post_rst", wr, a);
    chk("post_rst_write", wr, 0); chk("post_rst_addr", a, 8'h18);
    chk("post_rst_rvalid", o_rvalid, 1);
    chk("post_rst_rdata", o_rdata, 32'h0BADF00D);
    chk("post_rst_rresp", o_rresp, 0);
    chk("post_rst_awready", o_awready, 1);
    repeat (3) step();

    // random traffic, then drain
    slave_rand = 1'b1; rand_en = 1'b1; drv_on = 1'b1;
    repeat (4000) step();
    rand_en = 1'b0;
    repeat (40) step();
    drv_on = 1'b0;
    @(negedge i_clk);
    chk("drain_no_response", o_bvalid || o_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
